// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the 1 ms enable divider.
// Optional 10 ms output is built when CLKDIV_10MS_EN is defined.
`timescale 1ns/1ps
package clkdiv_pkg;

  localparam int unsigned CLK_FREQ_HZ_DEF = 16000000;
  localparam int unsigned TICK_HZ_DEF = 1000;
  localparam int unsigned DECADE = 10;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_INC,
    OP_WRAP,
    OP_CLEAR
  } cnt_op_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned cnt_width(
    input int unsigned n
  );
    int unsigned w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if (((n - 1) >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/clkdiv_cnt.sv
// Generic modulo-N counter with sync clear, enable and a wrap tick.
// The tick is combinational; the caller registers it.
`timescale 1ns/1ps
import clkdiv_pkg::*;

module clkdiv_cnt #(
  parameter int unsigned N = DECADE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int unsigned W = cnt_width(N);
  localparam logic [W-1:0] LAST = W'(N - 1);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nxt;
  logic         at_last;
  cnt_op_e      op;

  assign at_last = (cnt == LAST);

  always_comb begin
    op = OP_HOLD;
    unique case (1'b1)
      clear:                      op = OP_CLEAR;
      (!clear && en && at_last):  op = OP_WRAP;
      (!clear && en && !at_last): op = OP_INC;
      default:                    op = OP_HOLD;
    endcase
  end

  always_comb begin
    cnt_nxt = cnt;
    unique case (op)
      OP_CLEAR: cnt_nxt = '0;
      OP_WRAP:  cnt_nxt = '0;
      OP_INC:   cnt_nxt = cnt + ONE;
      default:  cnt_nxt = cnt;
    endcase
  end

  assign tick = (op == OP_WRAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

endmodule

// File: rtl/clk_div_1ms.sv
// Clock-enable divider: one-cycle O_EN_1MS every CLK_FREQ_HZ/TICK_HZ cycles.
// Define CLKDIV_10MS_EN to add O_EN_10MS (every tenth O_EN_1MS).
`timescale 1ns/1ps
import clkdiv_pkg::*;

module clk_div_1ms #(
  parameter int unsigned CLK_FREQ_HZ = CLK_FREQ_HZ_DEF,
  parameter int unsigned TICK_HZ = TICK_HZ_DEF
) (
  input  logic I_CLK,
  input  logic I_RSTN,
  input  logic I_CLEAR_EN,
  input  logic I_START_EN,
  output logic O_EN_1MS
`ifdef CLKDIV_10MS_EN
  ,
  output logic O_EN_10MS
`endif
);

  localparam int unsigned DIV = CLK_FREQ_HZ / TICK_HZ;

  if (DIV < 2 || (CLK_FREQ_HZ % TICK_HZ) != 0) begin : g_bad_cfg
    $fatal(1, "clk_div_1ms: need DIV>=2 and exact divide");
  end

  logic tick_1ms;

  clkdiv_cnt #(
    .N(DIV)
  ) u_cnt_1ms (
    .clk  (I_CLK),
    .rst_n(I_RSTN),
    .clear(I_CLEAR_EN),
    .en   (I_START_EN),
    .tick (tick_1ms)
  );

  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) O_EN_1MS <= 1'b0;
    else         O_EN_1MS <= tick_1ms;
  end

`ifdef CLKDIV_10MS_EN
  logic tick_10ms;

  // Decade advances only on edges that set O_EN_1MS, so both pulses align.
  clkdiv_cnt #(
    .N(DECADE)
  ) u_cnt_10ms (
    .clk  (I_CLK),
    .rst_n(I_RSTN),
    .clear(I_CLEAR_EN),
    .en   (tick_1ms),
    .tick (tick_10ms)
  );

  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) O_EN_10MS <= 1'b0;
    else         O_EN_10MS <= tick_10ms;
  end
`endif

endmodule

// File: tb/tb_clk_div_1ms.sv
// Directed bench for clk_div_1ms: DIV=8 instance plus a default instance.
// Covers O_EN_10MS too when CLKDIV_10MS_EN is defined.
`timescale 1ns/1ps
module tb_clk_div_1ms;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clear = 1'b0;
  logic start = 1'b1;
  logic en_1ms;
  logic en_1ms_def;
`ifdef CLKDIV_10MS_EN
  logic en_10ms;
  logic en_10ms_def;
`endif

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  clk_div_1ms #(
    .CLK_FREQ_HZ(8000),
    .TICK_HZ    (1000)
  ) dut (
    .I_CLK     (clk),
    .I_RSTN    (rst_n),
    .I_CLEAR_EN(clear),
    .I_START_EN(start),
    .O_EN_1MS  (en_1ms)
`ifdef CLKDIV_10MS_EN
    ,
    .O_EN_10MS (en_10ms)
`endif
  );

  clk_div_1ms dut_def (
    .I_CLK     (clk),
    .I_RSTN    (rst_n),
    .I_CLEAR_EN(1'b0),
    .I_START_EN(1'b1),
    .O_EN_1MS  (en_1ms_def)
`ifdef CLKDIV_10MS_EN
    ,
    .O_EN_10MS (en_10ms_def)
`endif
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d exp %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n edges; the pulse must appear only after the last one
  task automatic run_to_pulse(input string tag, input int n);
    for (int i = 1; i <= n; i++) begin
      step();
      chk(tag, {31'b0, en_1ms}, {31'b0, (i == n)});
    end
  endtask

  task automatic run_quiet(input string tag, input int n);
    for (int i = 1; i <= n; i++) begin
      step();
      chk(tag, {31'b0, en_1ms}, 32'd0);
    end
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    #100;
    chk("rst_1ms", {31'b0, en_1ms}, 32'd0);
    chk("rst_def", {31'b0, en_1ms_def}, 32'd0);
`ifdef CLKDIV_10MS_EN
    chk("rst_10ms", {31'b0, en_10ms}, 32'd0);
`endif
    step();
    rst_n = 1'b1;

    run_to_pulse("first", 8);
    run_to_pulse("period", 8);
    run_to_pulse("period2", 8);

    run_quiet("run3", 3);
    start = 1'b0;
    run_quiet("pause", 5);
    start = 1'b1;
    run_to_pulse("resume", 5);

    run_quiet("run7", 7);
    start = 1'b0;
    run_quiet("pause_last", 3);
    start = 1'b1;
    run_to_pulse("resume_last", 1);

    run_quiet("clr_pre", 6);
    clear = 1'b1;
    run_quiet("clr_hold", 2);
    clear = 1'b0;
    run_to_pulse("clr_rel", 8);

    run_quiet("clr7_pre", 7);
    clear = 1'b1;
    step();
    chk("clr_at_last", {31'b0, en_1ms}, 32'd0);
    clear = 1'b0;
    run_to_pulse("clr7_rel", 8);

    run_quiet("rst5_pre", 5);
    #2 rst_n = 1'b0;
    #1 chk("rst5_out", {31'b0, en_1ms}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    run_to_pulse("rst5_rel", 8);

    #2 rst_n = 1'b0;
    #1 chk("async_rst", {31'b0, en_1ms}, 32'd0);
    step();
    rst_n = 1'b1;
    run_to_pulse("async_rel", 8);

`ifdef CLKDIV_10MS_EN
    do_reset();
    for (int i = 1; i <= 80; i++) begin
      step();
      chk("dec_1ms", {31'b0, en_1ms}, {31'b0, (i % 8 == 0)});
      chk("dec_10ms", {31'b0, en_10ms}, {31'b0, (i == 80)});
    end
`endif

    do_reset();
    n = 0;
    do begin
      step();
      n++;
    end while (!en_1ms_def && n < 20000);
    chk("def_first", 32'(n), 32'd16000);
    n = 0;
    do begin
      step();
      n++;
    end while (!en_1ms_def && n < 20000);
    chk("def_period", 32'(n), 32'd16000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
